uart_apb_regs: RTL and testbench

//  APB3 slave register file placed directly upstream of uart_tx_top. It decodes CPU

---
 rtl/uart_apb_regs_if.sv | 25 ++
 rtl/uart_apb_regs.sv | 209 ++++++++++++++++++++
 tb/tb_uart_apb_regs.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_apb_regs_if.sv
// APB3 slave-side bus bundle for uart_apb_regs.
// Ports (slave view): psel_i, penable_i, pwrite_i, paddr_i[ADDR_W], pwdata_i[32] in;
//                     prdata_o[32], pready_o, pslverr_o out.
interface uart_apb_regs_if #(
  parameter int unsigned ADDR_W = 4
) ();
  logic              psel_i;
  logic              penable_i;
  logic              pwrite_i;
  logic [ADDR_W-1:0] paddr_i;
  logic [31:0]       pwdata_i;
  logic [31:0]       prdata_o;
  logic              pready_o;
  logic              pslverr_o;

  modport master (
    output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
    input  prdata_o, pready_o, pslverr_o
  );

  modport slave (
    input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
    output prdata_o, pready_o, pslverr_o
  );
endinterface

// File: rtl/uart_apb_regs.sv
// APB3 register file in front of uart_tx_top: BAUD, CTRL, STAT, TXDAT.
// Ports:
//   clk_i, rstn_i          clock, async active-low reset
//   apb                    APB3 slave bundle (uart_apb_regs_if.slave)
//   baud_div_o[16]         baud divisor to the transmitter
//   tx_active_o            transmitter enable
//   tx_wr_en_o, tx_wdata_o one-cycle TX data write strobe and byte
//   tx_full_i, tx_empty_i  FIFO flags
//   tx_sent_i              byte-complete level
//   irq_o                  level interrupt
module uart_apb_regs #(
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned BAUD_DIV_RST = 868
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  uart_apb_regs_if.slave        apb,
  output logic [15:0]           baud_div_o,
  output logic                  tx_active_o,
  output logic                  tx_wr_en_o,
  output logic [7:0]            tx_wdata_o,
  input  logic                  tx_full_i,
  input  logic                  tx_empty_i,
  input  logic                  tx_sent_i,
  output logic                  irq_o
);

  localparam int unsigned BAUD_W = 16;
  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] REG_BAUD  = 2'd0;
  localparam logic [1:0] REG_CTRL  = 2'd1;
  localparam logic [1:0] REG_STAT  = 2'd2;
  localparam logic [1:0] REG_TXDAT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [DATA_W-1:0] r_prdata;
  logic              r_pready;
  logic              r_pslverr;
  logic [BAUD_W-1:0] r_baud;
  logic              r_tx_active;
  logic              r_ie_sent;
  logic              r_ie_empty;
  logic              r_sticky;
  logic              r_sent_d;
  logic              r_wr_en;
  logic [7:0]        r_wdata;
  logic              r_irq;

  logic [DATA_W-1:0] w_prdata_nxt;
  logic              w_pready_nxt;
  logic              w_pslverr_nxt;
  logic [BAUD_W-1:0] w_baud_nxt;
  logic              w_tx_active_nxt;
  logic              w_ie_sent_nxt;
  logic              w_ie_empty_nxt;
  logic              w_sticky_nxt;
  logic              w_sticky_clr;
  logic              w_wr_en_nxt;
  logic [7:0]        w_wdata_nxt;
  logic              w_irq_nxt;

  logic [DATA_W-1:0] w_addr;
  logic [1:0]        w_sel;
  logic              w_bad;
  logic              w_act;
  logic              w_sent_rise;
  logic              w_unused;

  // Address decode: word index in [3:2], anything above bit 3 is out of map
  assign w_addr   = DATA_W'(apb.paddr_i);
  assign w_sel    = w_addr[3:2];
  assign w_bad    = |w_addr[DATA_W-1:4];
  assign w_unused = ^{w_addr[1:0], apb.pwdata_i[31:16]};

  // Register action only on a properly set-up access (SETUP state with penable high)
  assign w_act       = (r_state == ST_SETUP) && apb.psel_i && apb.penable_i;
  assign w_sent_rise = tx_sent_i && !r_sent_d;

  // State register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic; penable in IDLE without a setup phase is ignored
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (apb.psel_i && !apb.penable_i) w_state_nxt = ST_SETUP;
      ST_SETUP:  w_state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        if (apb.psel_i && !apb.penable_i) w_state_nxt = ST_SETUP;
        else                              w_state_nxt = ST_IDLE;
      end
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Output / register next-value logic
  always_comb begin
    w_prdata_nxt    = '0;
    w_pready_nxt    = (r_state == ST_SETUP);
    w_pslverr_nxt   = 1'b0;
    w_baud_nxt      = r_baud;
    w_tx_active_nxt = r_tx_active;
    w_ie_sent_nxt   = r_ie_sent;
    w_ie_empty_nxt  = r_ie_empty;
    w_sticky_clr    = 1'b0;
    w_wr_en_nxt     = 1'b0;
    w_wdata_nxt     = r_wdata;

    if (w_act) begin
      if (w_bad) begin
        w_pslverr_nxt = 1'b1;
      end else begin
        case (w_sel)
          REG_BAUD: begin
            if (apb.pwrite_i) begin
              // Divisor of zero would stall the baud generator
              w_baud_nxt = (apb.pwdata_i[15:0] == 16'd0) ? 16'd1 : apb.pwdata_i[15:0];
            end else begin
              w_prdata_nxt = DATA_W'(r_baud);
            end
          end
          REG_CTRL: begin
            if (apb.pwrite_i) begin
              w_tx_active_nxt = apb.pwdata_i[0];
              w_ie_sent_nxt   = apb.pwdata_i[1];
              w_ie_empty_nxt  = apb.pwdata_i[2];
            end else begin
              w_prdata_nxt = DATA_W'({r_ie_empty, r_ie_sent, r_tx_active});
            end
          end
          REG_STAT: begin
            if (apb.pwrite_i) begin
              w_sticky_clr = apb.pwdata_i[2];
            end else begin
              w_prdata_nxt = DATA_W'({r_sticky, tx_empty_i, tx_full_i});
            end
          end
          REG_TXDAT: begin
            if (apb.pwrite_i) begin
              if (tx_full_i) begin
                w_pslverr_nxt = 1'b1;
              end else begin
                w_wdata_nxt = apb.pwdata_i[7:0];
                w_wr_en_nxt = 1'b1;
              end
            end
          end
        endcase
      end
    end

    // A new completion edge beats a simultaneous W1C
    w_sticky_nxt = w_sent_rise || (r_sticky && !w_sticky_clr);
    w_irq_nxt    = (r_sticky && r_ie_sent) || (tx_empty_i && r_ie_empty);
  end

  // Registered outputs and control/status state
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_prdata    <= '0;
      r_pready    <= 1'b0;
      r_pslverr   <= 1'b0;
      r_baud      <= BAUD_W'(BAUD_DIV_RST);
      r_tx_active <= 1'b0;
      r_ie_sent   <= 1'b0;
      r_ie_empty  <= 1'b0;
      r_sticky    <= 1'b0;
      r_sent_d    <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wdata     <= '0;
      r_irq       <= 1'b0;
    end else begin
      r_prdata    <= w_prdata_nxt;
      r_pready    <= w_pready_nxt;
      r_pslverr   <= w_pslverr_nxt;
      r_baud      <= w_baud_nxt;
      r_tx_active <= w_tx_active_nxt;
      r_ie_sent   <= w_ie_sent_nxt;
      r_ie_empty  <= w_ie_empty_nxt;
      r_sticky    <= w_sticky_nxt;
      r_sent_d    <= tx_sent_i;
      r_wr_en     <= w_wr_en_nxt;
      r_wdata     <= w_wdata_nxt;
      r_irq       <= w_irq_nxt;
    end
  end

  assign apb.prdata_o  = r_prdata;
  assign apb.pready_o  = r_pready;
  assign apb.pslverr_o = r_pslverr;
  assign baud_div_o    = r_baud;
  assign tx_active_o   = r_tx_active;
  assign tx_wr_en_o    = r_wr_en;
  assign tx_wdata_o    = r_wdata;
  assign irq_o         = r_irq;

endmodule

// File: tb/tb_uart_apb_regs.sv
// Self-checking bench for uart_apb_regs (ADDR_W=5 so 0x10 is out of map).
module tb_uart_apb_regs;

  localparam int unsigned AW = 5;

  logic        clk_i;
  logic        rstn_i;
  logic [15:0] baud_div_o;
  logic        tx_active_o;
  logic        tx_wr_en_o;
  logic [7:0]  tx_wdata_o;
  logic        tx_full_i;
  logic        tx_empty_i;
  logic        tx_sent_i;
  logic        irq_o;

  int n_cmp;
  int n_err;

  uart_apb_regs_if #(.ADDR_W(AW)) apb_if ();

  uart_apb_regs #(.ADDR_W(AW), .BAUD_DIV_RST(868)) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .apb         (apb_if.slave),
    .baud_div_o  (baud_div_o),
    .tx_active_o (tx_active_o),
    .tx_wr_en_o  (tx_wr_en_o),
    .tx_wdata_o  (tx_wdata_o),
    .tx_full_i   (tx_full_i),
    .tx_empty_i  (tx_empty_i),
    .tx_sent_i   (tx_sent_i),
    .irq_o       (irq_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic          full;
    logic          empty;
    logic [31:0]   exp_rdata;
    logic          exp_err;
    logic          exp_wr_en;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One APB transfer: setup, access, wait for pready, then one extra edge to finish
  task automatic apb_xfer(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wdata,
                          input logic full, input logic empty,
                          output logic [31:0] rdata, output logic err,
                          output logic wr_en, output logic wr_en_after);
    int waits;
    @(negedge clk_i);
    tx_full_i         = full;
    tx_empty_i        = empty;
    apb_if.psel_i     = 1'b1;
    apb_if.penable_i  = 1'b0;
    apb_if.pwrite_i   = wr;
    apb_if.paddr_i    = addr;
    apb_if.pwdata_i   = wdata;
    @(negedge clk_i);
    apb_if.penable_i  = 1'b1;
    waits = 0;
    rdata = '0; err = 1'b0; wr_en = 1'b0; wr_en_after = 1'b0;
    while (waits < 4) begin
      @(posedge clk_i); #1;
      waits++;
      if (apb_if.pready_o) break;
    end
    if (!apb_if.pready_o) begin
      chk("pready_timeout", 32'(apb_if.pready_o), 32'd1);
    end else begin
      chk("pready_latency", 32'(waits), 32'd1);
      rdata = apb_if.prdata_o;
      err   = apb_if.pslverr_o;
      wr_en = tx_wr_en_o;
      @(posedge clk_i); #1;
      chk("pready_drop", {apb_if.pready_o, apb_if.pslverr_o, apb_if.prdata_o[29:0]}, 32'd0);
      wr_en_after = tx_wr_en_o;
    end
    apb_if.psel_i    = 1'b0;
    apb_if.penable_i = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  logic [31:0] rd;
  logic        er, we, we2;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rstn_i           = 1'b0;
    tx_full_i        = 1'b0;
    tx_empty_i       = 1'b1;
    tx_sent_i        = 1'b0;
    apb_if.psel_i    = 1'b0;
    apb_if.penable_i = 1'b0;
    apb_if.pwrite_i  = 1'b0;
    apb_if.paddr_i   = '0;
    apb_if.pwdata_i  = '0;

    //            wr    addr    wdata          full  empty exp_rdata     err   wr_en
    vecs[0]  = '{1'b0, 5'h08, 32'h0,         1'b0, 1'b1, 32'h2,        1'b0, 1'b0};
    vecs[1]  = '{1'b0, 5'h00, 32'h0,         1'b0, 1'b1, 32'd868,      1'b0, 1'b0};
    vecs[2]  = '{1'b0, 5'h04, 32'h0,         1'b0, 1'b1, 32'h0,        1'b0, 1'b0};
    vecs[3]  = '{1'b1, 5'h00, 32'h0036,      1'b0, 1'b1, 32'h0,        1'b0, 1'b0};
    vecs[4]  = '{1'b0, 5'h00, 32'h0,         1'b0, 1'b1, 32'h36,       1'b0, 1'b0};
    vecs[5]  = '{1'b1, 5'h00, 32'h0,         1'b0, 1'b1, 32'h0,        1'b0, 1'b0};
    vecs[6]  = '{1'b0, 5'h00, 32'h0,         1'b0, 1'b1, 32'h1,        1'b0, 1'b0};
    vecs[7]  = '{1'b1, 5'h03, 32'hABCD1234,  1'b0, 1'b1, 32'h0,        1'b0, 1'b0};
    vecs[8]  = '{1'b0, 5'h00, 32'h0,         1'b0, 1'b1, 32'h1234,     1'b0, 1'b0};
    vecs[9]  = '{1'b1, 5'h0C, 32'h1A5,       1'b0, 1'b1, 32'h0,        1'b0, 1'b1};
    vecs[10] = '{1'b1, 5'h0C, 32'h5A,        1'b1, 1'b0, 32'h0,        1'b1, 1'b0};
    vecs[11] = '{1'b0, 5'h0C, 32'h0,         1'b0, 1'b1, 32'h0,        1'b0, 1'b0};
    vecs[12] = '{1'b0, 5'h10, 32'h0,         1'b0, 1'b1, 32'h0,        1'b1, 1'b0};
    vecs[13] = '{1'b1, 5'h14, 32'hFF,        1'b0, 1'b1, 32'h0,        1'b1, 1'b0};
    vecs[14] = '{1'b1, 5'h04, 32'h3,         1'b0, 1'b1, 32'h0,        1'b0, 1'b0};
    vecs[15] = '{1'b0, 5'h04, 32'h0,         1'b0, 1'b1, 32'h3,        1'b0, 1'b0};
    vecs[16] = '{1'b0, 5'h08, 32'h0,         1'b1, 1'b0, 32'h1,        1'b0, 1'b0};

    // Reset values
    #12;
    chk("rst_baud",   32'(baud_div_o), 32'd868);
    chk("rst_outs",   {27'd0, tx_active_o, tx_wr_en_o, irq_o, apb_if.pready_o, apb_if.pslverr_o}, 32'd0);
    chk("rst_prdata", apb_if.prdata_o, 32'd0);
    chk("rst_wdata",  32'(tx_wdata_o), 32'd0);
    @(negedge clk_i);
    rstn_i = 1'b1;

    // Table-driven register accesses
    for (int i = 0; i < NV; i++) begin
      apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].full, vecs[i].empty,
               rd, er, we, we2);
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("v%0d_slverr", i), 32'(er), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_wr_en", i), 32'(we), 32'(vecs[i].exp_wr_en));
      chk($sformatf("v%0d_wr_en_after", i), 32'(we2), 32'd0);
    end
    tx_full_i  = 1'b0;
    tx_empty_i = 1'b1;
    chk("post_baud",   32'(baud_div_o), 32'h1234);
    chk("post_active", 32'(tx_active_o), 32'd1);
    chk("post_wdata",  32'(tx_wdata_o), 32'hA5);

    // Sent sticky and interrupt (ie_sent=1 from CTRL=0x3)
    chk("irq_idle", 32'(irq_o), 32'd0);
    @(negedge clk_i);
    tx_sent_i = 1'b1;
    wait_cycles(3);
    chk("irq_sent", 32'(irq_o), 32'd1);
    apb_xfer(1'b0, 5'h08, 32'h0, 1'b0, 1'b1, rd, er, we, we2);
    chk("stat_sticky", rd, 32'h6);
    apb_xfer(1'b1, 5'h08, 32'h4, 1'b0, 1'b1, rd, er, we, we2);
    wait_cycles(2);
    apb_xfer(1'b0, 5'h08, 32'h0, 1'b0, 1'b1, rd, er, we, we2);
    chk("stat_cleared", rd, 32'h2);
    chk("irq_cleared", 32'(irq_o), 32'd0);

    // Empty interrupt enable
    apb_xfer(1'b1, 5'h04, 32'h5, 1'b0, 1'b1, rd, er, we, we2);
    wait_cycles(2);
    chk("irq_empty", 32'(irq_o), 32'd1);
    @(negedge clk_i);
    tx_empty_i = 1'b0;
    wait_cycles(2);
    chk("irq_not_empty", 32'(irq_o), 32'd0);

    // penable without setup is ignored
    @(negedge clk_i);
    apb_if.psel_i    = 1'b1;
    apb_if.penable_i = 1'b1;
    apb_if.pwrite_i  = 1'b1;
    apb_if.paddr_i   = 5'h00;
    apb_if.pwdata_i  = 32'h77;
    wait_cycles(1);
    chk("proto_pready", 32'(apb_if.pready_o), 32'd0);
    wait_cycles(2);
    chk("proto_pready2", 32'(apb_if.pready_o), 32'd0);
    apb_if.psel_i    = 1'b0;
    apb_if.penable_i = 1'b0;
    wait_cycles(1);
    chk("proto_baud", 32'(baud_div_o), 32'h1234);

    // Reset asserted during ACCESS drops the pending write pulse
    @(negedge clk_i);
    tx_full_i        = 1'b0;
    apb_if.psel_i    = 1'b1;
    apb_if.penable_i = 1'b0;
    apb_if.pwrite_i  = 1'b1;
    apb_if.paddr_i   = 5'h0C;
    apb_if.pwdata_i  = 32'h3C;
    @(negedge clk_i);
    apb_if.penable_i = 1'b1;
    wait_cycles(1);
    chk("mid_pready", 32'(apb_if.pready_o), 32'd1);
    chk("mid_wr_en",  32'(tx_wr_en_o), 32'd1);
    rstn_i = 1'b0;
    #1;
    chk("mid_rst_outs", {26'd0, tx_active_o, tx_wr_en_o, irq_o, apb_if.pready_o,
                         apb_if.pslverr_o, 1'b0}, 32'd0);
    chk("mid_rst_baud",  32'(baud_div_o), 32'd868);
    chk("mid_rst_wdata", 32'(tx_wdata_o), 32'd0);
    apb_if.psel_i    = 1'b0;
    apb_if.penable_i = 1'b0;
    @(negedge clk_i);
    rstn_i = 1'b1;
    apb_xfer(1'b0, 5'h04, 32'h0, 1'b0, 1'b1, rd, er, we, we2);
    chk("after_rst_ctrl", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
